// File: rtl/game_pkg.sv
// Shared player-state types and lives constants for the game logic.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package game_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ALIVE   = 3'd1,
        EXPLODE = 3'd2,
        RESPAWN = 3'd3,
        OUT     = 3'd4
    } player_state_t;

    localparam int LIVES_W   = 2;
    localparam int MAX_LIVES = 3;

    // Saturating decrement of a lives count (never wraps below zero).
    function automatic logic [LIVES_W-1:0] lives_dec(input logic [LIVES_W-1:0] l);
        return (l == '0) ? l : l - 1'b1;
    endfunction

    // Saturating increment of a lives count (never exceeds MAX_LIVES).
    function automatic logic [LIVES_W-1:0] lives_inc(input logic [LIVES_W-1:0] l);
        return (l == LIVES_W'(MAX_LIVES)) ? l : l + 1'b1;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Loadable down-counter advancing once per video frame; expire_o flags the last tick.
// Latency: load/decrement visible one clk later; expire_o is same-cycle on count==1 && tick.
// Backpressure: none; en_i low holds the count regardless of frame_tick_i.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    input  logic         frame_tick_i,
    output logic [W-1:0] count_o,
    output logic         expire_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: clear beats load beats decrement; zero never wraps.
    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (load_i) begin
            count_d = load_val_i;
        end else if (en_i && frame_tick_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o  = count_q;
    assign expire_o = en_i && frame_tick_i && (count_q == W'(1));

endmodule

// File: rtl/player_lives.sv
// Player lives / explosion / respawn-invulnerability tracker; optional PLAYER_LIVES_EXTRA_LIFE_EN.
// Latency: hit -> lives and flags one clk later; all outputs decoded from registers only.
// Backpressure: none; spawn low freezes state, lives and timer (pulses dropped).
module player_lives
    import game_pkg::*;
#(
    parameter int START_LIVES   = 3,
    parameter int DEATH_FRAMES  = 60,
    parameter int INVULN_FRAMES = 120,
    parameter int BLINK_LOG2    = 3
) (
    input  logic               clk,
    input  logic               Reset,
    input  logic               spawn,
    input  logic               reset_characters,
    input  logic               frame_tick,
    input  logic               player_hit,
    input  logic               extra_life,
    output logic [LIVES_W-1:0] lives,
    output logic               player_active,
    output logic               player_visible,
    output logic               exploding
);

    localparam int MAX_FRAMES = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
    localparam int TMR_W      = $clog2(MAX_FRAMES + 1);

    player_state_t      state_q, state_d;
    logic [LIVES_W-1:0] lives_q, lives_d;

    logic               tmr_clear;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_load_val;
    logic               tmr_en;
    logic [TMR_W-1:0]   tmr_cnt;
    logic               tmr_expire;
    logic               blink_bit;
    logic               xl_pulse;

    frame_timer #(
        .W (TMR_W)
    ) u_timer (
        .clk          (clk),
        .rst          (Reset),
        .clear_i      (tmr_clear),
        .load_i       (tmr_load),
        .load_val_i   (tmr_load_val),
        .en_i         (tmr_en),
        .frame_tick_i (frame_tick),
        .count_o      (tmr_cnt),
        .expire_o     (tmr_expire)
    );

`ifdef PLAYER_LIVES_EXTRA_LIFE_EN
    assign xl_pulse = extra_life;
`else
    // The port stays for a uniform interface but carries no function.
    logic unused_extra_life;
    assign unused_extra_life = extra_life;
    assign xl_pulse          = 1'b0;
`endif

    // Only one timer bit drives the blink; the rest just counts.
    logic unused_tmr_bits;
    assign unused_tmr_bits = ^tmr_cnt;

    if (BLINK_LOG2 < TMR_W) begin : g_blink
        assign blink_bit = tmr_cnt[BLINK_LOG2];
    end else begin : g_no_blink
        assign blink_bit = 1'b0;
    end

    // Next-state, lives and timer control; reset_characters outranks the spawn freeze.
    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        tmr_clear    = 1'b0;
        tmr_load     = 1'b0;
        tmr_load_val = '0;
        tmr_en       = 1'b0;

        if (reset_characters) begin
            state_d   = IDLE;
            lives_d   = LIVES_W'(START_LIVES);
            tmr_clear = 1'b1;
        end else if (spawn) begin
            // Extra life applies in every in-play state; a same-edge hit cancels it out below.
            if (xl_pulse && (state_q == ALIVE || state_q == EXPLODE || state_q == RESPAWN)) begin
                lives_d = lives_inc(lives_q);
            end

            unique case (state_q)
                IDLE: begin
                    state_d = ALIVE;
                end
                ALIVE: begin
                    if (player_hit) begin
                        lives_d      = xl_pulse ? lives_q : lives_dec(lives_q);
                        tmr_load     = 1'b1;
                        tmr_load_val = TMR_W'(DEATH_FRAMES);
                        state_d      = EXPLODE;
                    end
                end
                EXPLODE: begin
                    tmr_en = 1'b1;
                    if (tmr_expire) begin
                        if (lives_d == '0) begin
                            state_d = OUT;
                        end else begin
                            tmr_load     = 1'b1;
                            tmr_load_val = TMR_W'(INVULN_FRAMES);
                            state_d      = RESPAWN;
                        end
                    end
                end
                RESPAWN: begin
                    tmr_en = 1'b1;
                    if (tmr_expire) begin
                        state_d = ALIVE;
                    end
                end
                OUT: begin
                    state_d = OUT;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State and lives registers.
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            lives_q <= LIVES_W'(START_LIVES);
        end else begin
            state_q <= state_d;
            lives_q <= lives_d;
        end
    end

    assign lives          = lives_q;
    assign player_active  = (state_q == ALIVE) || (state_q == RESPAWN);
    assign player_visible = (state_q == ALIVE) || ((state_q == RESPAWN) && !blink_bit);
    assign exploding      = (state_q == EXPLODE);

endmodule

// File: tb/tb_player_lives.sv
// Directed bench for player_lives with short timers (4-frame explosion, 16-frame invulnerability).
// Latency: checks sampled 1 time unit after each rising clk edge.
// Backpressure: exercises the spawn-low freeze and same-edge priority cases.
module tb_player_lives;

    logic       clk;
    logic       Reset;
    logic       spawn;
    logic       reset_characters;
    logic       frame_tick;
    logic       player_hit;
    logic       extra_life;
    logic [1:0] lives;
    logic       player_active;
    logic       player_visible;
    logic       exploding;

    int n_cmp = 0;
    int n_err = 0;

`ifdef PLAYER_LIVES_EXTRA_LIFE_EN
    localparam int XL = 1;
`else
    localparam int XL = 0;
`endif

    player_lives #(
        .START_LIVES   (3),
        .DEATH_FRAMES  (4),
        .INVULN_FRAMES (16),
        .BLINK_LOG2    (3)
    ) dut (
        .clk              (clk),
        .Reset            (Reset),
        .spawn            (spawn),
        .reset_characters (reset_characters),
        .frame_tick       (frame_tick),
        .player_hit       (player_hit),
        .extra_life       (extra_life),
        .lives            (lives),
        .player_active    (player_active),
        .player_visible   (player_visible),
        .exploding        (exploding)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock with the given pulses held for that edge only.
    task automatic cyc(input logic h, input logic ft, input logic rc, input logic xl);
        player_hit       = h;
        frame_tick       = ft;
        reset_characters = rc;
        extra_life       = xl;
        @(posedge clk);
        #1;
        player_hit       = 1'b0;
        frame_tick       = 1'b0;
        reset_characters = 1'b0;
        extra_life       = 1'b0;
    endtask

    // n frame ticks, each a one-clk pulse followed by a quiet clk.
    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1'b0, 1'b1, 1'b0, 1'b0);
            cyc(1'b0, 1'b0, 1'b0, 1'b0);
        end
    endtask

    // Compare {lives, active, visible, exploding} against expectation.
    task automatic chk(input string tag, input int l, input logic a, input logic v, input logic e);
        logic [4:0] obs;
        logic [4:0] exp;
        obs = {lives, player_active, player_visible, exploding};
        exp = {l[1:0], a, v, e};
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed lives/act/vis/expl=%b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        Reset            = 1'b1;
        spawn            = 1'b0;
        reset_characters = 1'b0;
        frame_tick       = 1'b0;
        player_hit       = 1'b0;
        extra_life       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset", 3, 0, 0, 0);
        Reset = 1'b0;
        cyc(0, 0, 0, 0);
        chk("idle_no_spawn", 3, 0, 0, 0);

        spawn = 1'b1;
        cyc(0, 0, 0, 0);
        chk("spawn_alive", 3, 1, 1, 0);

        // First hit and explosion timing
        cyc(1, 0, 0, 0);
        chk("hit1", 2, 0, 0, 1);
        cyc(1, 0, 0, 0);
        chk("hit_in_explode", 2, 0, 0, 1);
        ticks(3);
        chk("explode_3_ticks", 2, 0, 0, 1);
        ticks(1);
        chk("respawn_t16", 2, 1, 1, 0);
        ticks(1);
        chk("respawn_t15_blink", 2, 1, 0, 0);
        cyc(1, 0, 0, 0);
        chk("hit_in_respawn", 2, 1, 0, 0);
        ticks(7);
        chk("respawn_t8_blink", 2, 1, 0, 0);
        ticks(1);
        chk("respawn_t7_show", 2, 1, 1, 0);
        ticks(6);
        cyc(1, 0, 0, 0);
        chk("respawn_t1_hit", 2, 1, 1, 0);
        ticks(1);
        chk("alive_after_16", 2, 1, 1, 0);
        cyc(1, 1, 0, 0);
        chk("hit_plus_tick", 1, 0, 0, 1);

        // Freeze mid-explosion
        ticks(2);
        spawn = 1'b0;
        ticks(10);
        cyc(1, 0, 0, 0);
        chk("frozen_explode", 1, 0, 0, 1);
        spawn = 1'b1;
        ticks(1);
        chk("resume_t1", 1, 0, 0, 1);
        ticks(1);
        chk("resume_respawn", 1, 1, 1, 0);
        ticks(16);
        chk("alive_again", 1, 1, 1, 0);

        // Hit while frozen is dropped; hit + reset_characters
        spawn = 1'b0;
        cyc(1, 0, 0, 0);
        chk("hit_spawn_low", 1, 1, 1, 0);
        spawn = 1'b1;
        cyc(1, 0, 1, 0);
        chk("hit_plus_rc", 3, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rc_then_alive", 3, 1, 1, 0);

        // Three hits to game over
        cyc(1, 0, 0, 0);
        chk("go_hit1", 2, 0, 0, 1);
        ticks(20);
        chk("go_rec1", 2, 1, 1, 0);
        cyc(1, 0, 0, 0);
        chk("go_hit2", 1, 0, 0, 1);
        ticks(20);
        chk("go_rec2", 1, 1, 1, 0);
        cyc(1, 0, 0, 0);
        chk("go_hit3", 0, 0, 0, 1);
        ticks(3);
        chk("go_explode", 0, 0, 0, 1);
        ticks(1);
        chk("go_out", 0, 0, 0, 0);
        ticks(5);
        cyc(1, 0, 0, 0);
        chk("out_stays", 0, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("out_rc", 3, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("out_rc_alive", 3, 1, 1, 0);

        // Extra life
        cyc(0, 0, 0, 1);
        chk("xl_at_3", 3, 1, 1, 0);
        cyc(1, 0, 0, 0);
        ticks(20);
        cyc(1, 0, 0, 0);
        ticks(20);
        chk("xl_setup_1", 1, 1, 1, 0);
        cyc(0, 0, 0, 1);
        chk("xl_at_1", 1 + XL, 1, 1, 0);
        cyc(1, 0, 0, 1);
        chk("xl_plus_hit", (XL == 1) ? 2 : 0, 0, 0, 1);

        // Asynchronous reset between edges
        @(negedge clk);
        Reset = 1'b1;
        #1;
        chk("async_reset", 3, 0, 0, 0);
        Reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/player_lives.md
Name: player_lives

Overview:
- Tracks the player's remaining lives, death explosion and post-respawn invulnerability window.
- Produces the `lives` count that the game-flow state machine watches for game-over.
- Consumes that machine's `spawn` / `reset_characters` controls, plus a registered hit pulse from collision logic.
- Drives player sprite visibility and activity, and gates player movement and firing.

Parameters:
- START_LIVES, 3, lives loaded on reset and on reset_characters; legal range 1..3.
- DEATH_FRAMES, 60, frame ticks spent in the explosion; must be ≥1.
- INVULN_FRAMES, 120, frame ticks of invulnerability after respawn; must be ≥1.
- BLINK_LOG2, 3, timer bit that drives sprite blinking during invulnerability.

Ports:
- clk  input  1  system clock.
- Reset  input  1  asynchronous, active-high reset.
- spawn  input  1  high while in game; low freezes all state.
- reset_characters  input  1  synchronous re-initialise; highest priority after Reset.
- frame_tick  input  1  one-clk pulse per video frame; all timers advance only on it.
- player_hit  input  1  one-clk pulse from collision logic.
- extra_life  input  1  one-clk pulse from score logic; used only with EXTRA_LIFE_EN.
- lives  output  2  remaining lives, 0..3.
- player_active  output  1  player may move and fire.
- player_visible  output  1  draw the player sprite.
- exploding  output  1  draw the explosion sprite at the player position.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-high.
- Reset values (Reset or reset_characters):
  - state=IDLE, timer=0, lives=START_LIVES.
  - player_active=0, player_visible=0, exploding=0.
- All outputs are registered or decoded from registered state only; no combinational path from any input.
- Priority per edge: Reset > reset_characters > spawn low (hold everything) > state logic.
- States:
  - IDLE → ALIVE on the first edge with spawn=1. No timer involvement.
  - ALIVE:
    - player_active=1, player_visible=1.
    - player_hit: lives ← lives−1 (saturate at 0), timer ← DEATH_FRAMES, → EXPLODE, all on the same edge. One-cycle latency hit→lives.
  - EXPLODE:
    - exploding=1, player_active=0, player_visible=0; player_hit ignored.
    - Timer decrements on each frame_tick.
    - On the edge where timer==1 and frame_tick=1: if lives==0 → OUT; else timer ← INVULN_FRAMES and → RESPAWN.
    - Explosion therefore lasts exactly DEATH_FRAMES ticks.
  - RESPAWN:
    - player_active=1; player_hit ignored.
    - player_visible = ~timer[BLINK_LOG2].
    - Timer decrements on frame_tick; at timer==1 with frame_tick → ALIVE.
  - OUT:
    - lives=0, all flags 0.
    - Stays until reset_characters.
- Simultaneous events:
  - hit + frame_tick in ALIVE: hit taken.
  - hit + reset_characters: reset wins, no decrement.
  - hit while spawn=0: dropped.
- Game-flow interaction: lives reaches 0 on the hit edge, so game-over is signalled during the explosion. A subsequent reset_characters restores START_LIVES mid-explosion; this is correct behaviour.
- Timer width: clog2(max(DEATH_FRAMES, INVULN_FRAMES)+1).

Optional Feature:
- Macro: PLAYER_LIVES_EXTRA_LIFE_EN.
- Defined:
  - extra_life pulse increments lives, saturating at 3, in ALIVE, EXPLODE or RESPAWN; ignored in IDLE and OUT.
  - extra_life + player_hit on the same edge: net lives unchanged; the state still enters EXPLODE.
- Undefined: the extra_life port remains but is ignored; no increment logic is synthesised.

Decomposition:
- Shared package `game_pkg`:
  - enum `player_state_t` {IDLE, ALIVE, EXPLODE, RESPAWN, OUT}.
  - LIVES_W=2, MAX_LIVES=3.
- Sub-module `frame_timer`:
  - Loadable down-counter that decrements on frame_tick when enabled.
  - Raises `expire` when count==1 && frame_tick.
  - Instantiated once and shared by EXPLODE and RESPAWN.

Test Plan:
- Reset, then spawn=1 → IDLE→ALIVE next edge; lives=3, player_active=1, player_visible=1.
- Test timer parameters DEATH_FRAMES=4, INVULN_FRAMES=16; hit in ALIVE:
  - lives=2 one clk later, exploding=1.
  - After exactly 4 frame_ticks → RESPAWN; player_visible toggles with timer bit 3.
  - ALIVE after 16 ticks.
- Hit during EXPLODE and during RESPAWN → lives unchanged.
- Three hits separated by full recoveries → lives=0 on third hit edge; after DEATH_FRAMES → OUT. reset_characters → lives=3, IDLE.
- spawn=0 for 10 frame_ticks mid-EXPLODE → timer and state frozen; resumes with the remaining count. Hit + reset_characters on same edge → lives=3.
- With PLAYER_LIVES_EXTRA_LIFE_EN:
  - extra_life at lives=3 → stays 3.
  - extra_life at lives=1 → 2.
  - extra_life + hit at lives=2 → lives=2, EXPLODE.
- Without the macro: extra_life has no effect.
